// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
// key_debounce_if : pushbutton input and debounced outputs of key_debounce
// Revision        : 1.0
// ============================================================================
interface key_debounce_if;
  logic       key_n;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  modport master (
    output key_n,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  press_count
  );

  modport slave (
    input  key_n,
    output key_level,
    output press_pulse,
    output release_pulse,
    output press_count
  );
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : synchronises an active-low pushbutton and qualifies level
//                changes after DEBOUNCE_CYCLES stable samples.
// Revision     : 1.0
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  wire logic     CLOCK_50,
  input  wire logic     reset,
  key_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_PRESS   = 2'd1,
    S_PRESSED      = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press_evt;
  logic             w_release_evt;
  logic             r_press_pulse;
  logic             r_release_pulse;
  logic [7:0]       r_press_count;

  // Synchroniser idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter is cleared on every transition and only runs in the WAIT states.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = '0;
    w_press_evt   = 1'b0;
    w_release_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = S_WAIT_PRESS;
        end
      end
      S_WAIT_PRESS: begin
        if (r_sync2) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = S_PRESSED;
          w_press_evt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      S_PRESSED: begin
        if (r_sync2) begin
          w_state_nxt = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        if (!r_sync2) begin
          w_state_nxt = S_PRESSED;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt   = S_IDLE;
          w_release_evt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_press_count   <= 8'd0;
    end else begin
      r_press_pulse   <= w_press_evt;
      r_release_pulse <= w_release_evt;
      if (w_press_evt) begin
        r_press_count <= r_press_count + 8'd1;
      end
    end
  end

  assign bus.key_level     = (r_state == S_PRESSED) || (r_state == S_WAIT_RELEASE);
  assign bus.press_pulse   = r_press_pulse;
  assign bus.release_pulse = r_release_pulse;
  assign bus.press_count   = r_press_count;

`ifndef SYNTHESIS
  a_pulse_excl : assert property (@(posedge CLOCK_50) disable iff (reset)
    !(r_press_pulse && r_release_pulse));
  a_cnt_bound : assert property (@(posedge CLOCK_50) disable iff (reset)
    r_cnt <= C_CNT_LAST);
  a_cnt_idle : assert property (@(posedge CLOCK_50) disable iff (reset)
    ((r_state == S_IDLE) || (r_state == S_PRESSED)) |-> (r_cnt == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// tb_key_debounce : directed and randomized checks of key_debounce against a
//                   run-length reference model.
// Revision        : 1.0
// ============================================================================
module tb_key_debounce;

  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;

  key_debounce_if bus ();

  key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the synchronised key must disagree with the current debounced
  // level on D+1 consecutive edges before the level flips.
  bit m_s1 = 1'b1, m_s2 = 1'b1;
  bit m_level = 1'b0, m_press = 1'b0, m_release = 1'b0;
  int m_run = 0;
  int m_count = 0;

  always @(posedge clk) begin : p_model
    bit s;
    bit disagree;
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0;
      m_press = 1'b0; m_release = 1'b0; m_run = 0; m_count = 0;
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.key_n;
      m_press = 1'b0;
      m_release = 1'b0;
      disagree = m_level ? s : !s;
      m_run = disagree ? m_run + 1 : 0;
      if (m_run == D + 1) begin
        m_run = 0;
        m_level = !m_level;
        if (m_level) begin
          m_press = 1'b1;
          m_count = (m_count + 1) % 256;
        end else begin
          m_release = 1'b1;
        end
      end
    end
  end

  int seen_press = 0;
  int seen_release = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    chk("key_level", int'(bus.key_level), int'(m_level));
    chk("press_pulse", int'(bus.press_pulse), int'(m_press));
    chk("release_pulse", int'(bus.release_pulse), int'(m_release));
    chk("press_count", int'(bus.press_count), m_count);
    chk("pulse_excl", int'(bus.press_pulse & bus.release_pulse), 0);
    if (bus.press_pulse)   seen_press++;
    if (bus.release_pulse) seen_release++;
  endtask

  // lat = edge offset (0 = edge that first samples the new key level)
  task automatic wait_pulse(input bit want_press, input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (lat < 0 && (want_press ? bus.press_pulse : bus.release_pulse)) lat = i;
    end
  endtask

  initial begin
    int lat;
    int p0;
    int r0;
    int cyc;
    int val;
    int len;

    rst = 1'b1;
    bus.key_n = 1'b1;
    repeat (3) tick();
    chk("rst_level", int'(bus.key_level), 0);
    chk("rst_press", int'(bus.press_pulse), 0);
    chk("rst_release", int'(bus.release_pulse), 0);
    chk("rst_count", int'(bus.press_count), 0);
    rst = 1'b0;
    repeat (4) tick();

    // Clean press and release
    p0 = seen_press;
    bus.key_n = 1'b0;
    wait_pulse(1'b1, 12, lat);
    chk("press_lat", lat, D + 2);
    chk("press_once", seen_press - p0, 1);
    chk("press_level", int'(bus.key_level), 1);
    chk("press_cnt", int'(bus.press_count), 1);

    r0 = seen_release;
    bus.key_n = 1'b1;
    wait_pulse(1'b0, 12, lat);
    chk("release_lat", lat, D + 2);
    chk("release_once", seen_release - r0, 1);
    chk("release_level", int'(bus.key_level), 0);
    chk("release_cnt", int'(bus.press_count), 1);

    // Bounce: 3 low, 1 high, then held low
    p0 = seen_press;
    bus.key_n = 1'b0;
    repeat (3) tick();
    bus.key_n = 1'b1;
    tick();
    chk("bounce_quiet", seen_press - p0, 0);
    bus.key_n = 1'b0;
    wait_pulse(1'b1, 12, lat);
    chk("bounce_lat", lat, D + 2);
    chk("bounce_once", seen_press - p0, 1);
    chk("bounce_cnt", int'(bus.press_count), 2);

    bus.key_n = 1'b1;
    wait_pulse(1'b0, 12, lat);
    chk("release2_lat", lat, D + 2);
    chk("release2_cnt", int'(bus.press_count), 2);

    // Reset while in WAIT_PRESS with count = 2
    p0 = seen_press;
    bus.key_n = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("midrst_level", int'(bus.key_level), 0);
    chk("midrst_press", int'(bus.press_pulse), 0);
    chk("midrst_release", int'(bus.release_pulse), 0);
    chk("midrst_cnt", int'(bus.press_count), 0);
    chk("midrst_nopulse", seen_press - p0, 0);
    rst = 1'b0;
    wait_pulse(1'b1, 12, lat);
    chk("postrst_lat", lat, D + 2);
    chk("postrst_cnt", int'(bus.press_count), 1);

    // 256 clean press/release pairs wrap the press counter
    bus.key_n = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0 = seen_press;
    for (int n = 0; n < 256; n++) begin
      bus.key_n = 1'b0;
      repeat (D + 4) tick();
      bus.key_n = 1'b1;
      repeat (D + 4) tick();
    end
    chk("wrap_pulses", seen_press - p0, 256);
    chk("wrap_cnt", int'(bus.press_count), 0);

    // Random bouncy input with occasional resets
    cyc = 0;
    while (cyc < 3000) begin
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        len = $urandom_range(1, 2);
        repeat (len) tick();
        rst = 1'b0;
        cyc += len;
      end
      val = $urandom_range(0, 1);
      len = $urandom_range(1, D + 4);
      bus.key_n = val[0];
      repeat (len) tick();
      cyc += len;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable cycles that qualifies a level change (10 ms at 50 MHz); legal values SHALL be >= 2.
REQ-002 The block SHALL have parameter CNT_W, default 19, meaning the debounce counter width; CNT_W SHALL be >= clog2(DEBOUNCE_CYCLES).
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: the single system clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, driven at top level from ~KEY[1].
REQ-005 The block SHALL have port key_n, input, 1 bit: raw asynchronous pushbutton, active-low (0 = pressed).
REQ-006 The block SHALL have port key_level, output, 1 bit: debounced pressed level (1 = pressed).
REQ-007 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe on a qualified press, consumed as the clock enable of the downstream D-flip-flop/HEX display stage.
REQ-008 The block SHALL have port release_pulse, output, 1 bit: one-cycle strobe on a qualified release.
REQ-009 The block SHALL have port press_count, output, 8 bits: number of qualified presses since reset, modulo 256.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer; FSM and counter logic SHALL use only the second flop output (sync_n), never key_n directly.
REQ-011 The FSM SHALL have exactly four states: IDLE (stable released), WAIT_PRESS, PRESSED (stable pressed), WAIT_RELEASE.
REQ-012 In IDLE, if sync_n = 0, the FSM SHALL go to WAIT_PRESS with count = 0; otherwise it SHALL hold.
REQ-013 In WAIT_PRESS, if sync_n = 1 (bounce), the FSM SHALL return to IDLE with count = 0 and no pulse.
REQ-014 In WAIT_PRESS, if sync_n = 0 and count = DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED and clear count; otherwise count SHALL increment.
REQ-015 PRESSED/WAIT_RELEASE SHALL mirror REQ-012..014 with sync_n polarity inverted: a bounce SHALL return to PRESSED, and qualification SHALL go to IDLE.
REQ-016 key_level SHALL be 1 exactly when the state is PRESSED or WAIT_RELEASE.
REQ-017 press_pulse SHALL be registered and high for exactly the one cycle following the edge that enters PRESSED from WAIT_PRESS; it SHALL not be asserted on a WAIT_RELEASE->PRESSED bounce return.
REQ-018 release_pulse SHALL be registered and high for exactly the one cycle following the edge that enters IDLE from WAIT_RELEASE; it SHALL not be asserted on a WAIT_PRESS->IDLE bounce return.
REQ-019 Latency: if key_n is first sampled low at edge k and then held low, the FSM SHALL enter WAIT_PRESS at edge k+2, and PRESSED and press_pulse SHALL assert at edge k+2+DEBOUNCE_CYCLES; release latency SHALL be symmetric.
REQ-020 press_count SHALL increment on the same edge that asserts press_pulse, wrapping 255 -> 0 with no flag.
REQ-021 press_pulse and release_pulse SHALL never be high in the same cycle; either SHALL be high at most once per DEBOUNCE_CYCLES+1 cycles.
REQ-022 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL be 0 whenever the state is IDLE or PRESSED.

Reset
REQ-023 While reset = 1 at an edge, the block SHALL force state = IDLE, count = 0, both synchronizer flops = 1, key_level = 0, press_pulse = 0, release_pulse = 0, and press_count = 0.
REQ-024 A reset asserted mid-qualification (WAIT_PRESS/WAIT_RELEASE) or while PRESSED SHALL abort without emitting any pulse, and the press SHALL not be counted.
REQ-025 After reset deasserts with key_n already held low, the block SHALL qualify a fresh press per REQ-019, timed from the first post-reset edge.

Verification (DEBOUNCE_CYCLES = 4 in simulation)
REQ-026 Clean press: key_n 1->0 sampled at edge 10, held -> press_pulse high only in the cycle after edge 16, key_level = 1 from edge 16, press_count = 1.
REQ-027 Bounce: key_n low for 3 cycles, high for 1, then low and held -> no pulse during the bounce; press_pulse asserts 4+2 edges after the final falling sample; press_count = 1.
REQ-028 Release: from PRESSED, key_n held high -> release_pulse one cycle at edge +6, key_level = 0, press_count unchanged.
REQ-029 Wrap: 256 clean press/release pairs -> press_count = 0 and exactly 256 press_pulses are seen.
REQ-030 Reset mid-operation: assert reset in WAIT_PRESS with count = 2 -> next cycle state = IDLE, all outputs 0, and no press_pulse is emitted afterward until a full re-qualification.
